rgb_blob_box: RTL and testbench
===============================

Name: rgb_blob_box

Overview:
- Downstream consumer of the Bayer-to-RGB stage, clocked by the same pixel clock.
- Classifies each valid RGB pixel against a colour threshold window and accumulates a per-frame bounding box and match count for the rover's target tracker.
- At the end of each frame it latches the results and pulses a done strobe for the Avalon-MM/CPU side to sample.

Parameters:
- VIDEO_W, 1280, active pixels per line; X runs 0..VIDEO_W-1.
- VIDEO_H, 720, active lines per frame; Y runs 0..VIDEO_H-1.
- MIN_PIXELS, 16, minimum match count for BOX_FOUND=1.

Ports:
- RGB_CLK  in  1  pixel clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- RGB_R / RGB_G / RGB_B  in  12 each  pixel colour.
- RGB_X / RGB_Y  in  12 each  pixel coordinates.
- RGB_VALID  in  1  pixel qualifier.
- TH_R_MIN / TH_G_MAX / TH_B_MAX  in  12 each  threshold window; sampled at start of frame (SOF).
- BOX_X_MIN / BOX_X_MAX / BOX_Y_MIN / BOX_Y_MAX  out  12 each  last completed frame's bounding box.
- BOX_COUNT  out  20  matched pixels in the last frame; saturates at 2^20-1.
- BOX_FOUND  out  1  BOX_COUNT >= MIN_PIXELS.
- BOX_DONE  out  1  one-cycle strobe when results update.

Behaviour:
- Clocking and reset: one clock, RGB_CLK. Reset is synchronous, active-low (reset_n). Reset drives all outputs to 0, the FSM to S_WAIT_SOF, and clears both pipeline stages.
- Match rule: match = (R >= TH_R_MIN) & (G <= TH_G_MAX) & (B <= TH_B_MAX). Unsigned 12-bit compares against the latched thresholds.
- Pipeline: stage 1 registers match/X/Y/valid/sof/eof at edge k.
  - Stage 2 updates the accumulators at edge k+1.
  - Results and BOX_DONE are registered at edge k+2.
  - Total latency from the last pixel's sampling edge to BOX_DONE high: 2 cycles.
- Frame markers:
  - SOF = RGB_VALID & X==0 & Y==0.
  - EOF = RGB_VALID & X==VIDEO_W-1 & Y==VIDEO_H-1.
  - Pixels with RGB_VALID=0 are ignored entirely.
- FSM:
  - S_WAIT_SOF: ignore pixels until SOF. On SOF, latch the thresholds (the SOF pixel itself uses the newly latched values), load the accumulators from the SOF pixel (x_min=x_max=0 etc. if matched; empty otherwise), then go to S_ACCUM.
  - S_ACCUM: on each matched pixel:
    - x_min = min(x_min, X), x_max = max(x_max, X)
    - y_min = min(y_min, Y), y_max = max(y_max, Y)
    - count = count + 1, saturating.
  - S_ACCUM exits:
    - On EOF, go to S_DONE.
    - On an unexpected SOF (frame restart), reload the accumulators from that pixel and stay in S_ACCUM. No BOX_DONE.
    - On Y decreasing relative to the previous valid pixel (abort), discard and go to S_WAIT_SOF.
  - S_DONE (1 cycle): copy the accumulators to the outputs, assert BOX_DONE for exactly one cycle, return to S_WAIT_SOF.
  - A SOF arriving on the same cycle as S_DONE is honoured: thresholds latched, accumulators reloaded, next state S_ACCUM.
- Empty accumulator state: x_min=y_min=12'hFFF, x_max=y_max=0, count=0.
- Results on BOX_FOUND=0: all four box outputs are forced to 0; BOX_COUNT still reports the true count.
- Output hold: outputs hold their values between BOX_DONE strobes.
- Reset mid-frame: frame discarded, outputs 0; the next SOF starts a fresh frame.

Optional Feature:
- Macro RGB_BLOB_CENTROID_EN.
- Defined:
  - Adds outputs BOX_SUM_X and BOX_SUM_Y, 32 bits each: sums of X and Y over matched pixels.
  - Accumulated in stage 2; saturating; latched with the other results on BOX_DONE; 0 on reset or !BOX_FOUND.
  - Software divides by BOX_COUNT to get the centroid.
- Undefined: ports and logic absent; all other behaviour unchanged.

Decomposition:
- Package rgb_blob_pkg holds:
  - the state enum (S_WAIT_SOF, S_ACCUM, S_DONE);
  - width constants COORD_W=12, COLOR_W=12, COUNT_W=20, SUM_W=32;
  - empty-accumulator constants.
- One sub-module, rgb_blob_classify: stage 1 only (threshold compares, SOF/EOF decode, register slice).
- The top holds the FSM, accumulators and output registers.

Test Plan (bench uses VIDEO_W=8, VIDEO_H=4, MIN_PIXELS=2, thresholds 0x800/0x100/0x100):
- Frame with matches (R=0xFFF,G=0,B=0) at (2,1),(5,1),(3,2); others R=0 -> 2 cycles after EOF sample, BOX_DONE=1 for 1 cycle; box (2,5,1,2); COUNT=3; FOUND=1.
- Frame with a single match at (7,3) -> COUNT=1, FOUND=0, box outputs all 0, BOX_DONE pulses.
- Frame with RGB_VALID gaps every other cycle and the same pixels as scenario 1 -> identical results.
- Y drops from 2 to 0 with X=4 mid-frame (abort) -> no BOX_DONE; outputs keep the previous frame's values; the next full frame reports normally.
- reset_n=0 for 1 cycle mid-frame after a completed frame -> all outputs 0 next edge; no BOX_DONE until a full SOF..EOF frame completes.
- With RGB_BLOB_CENTROID_EN, scenario 1 -> BOX_SUM_X=10, BOX_SUM_Y=4.

Source files
------------

// File: rtl/rgb_blob_pkg.sv
// Shared types and constants for the RGB blob bounding-box tracker.
package rgb_blob_pkg;

    localparam int COORD_W = 12;
    localparam int COLOR_W = 12;
    localparam int COUNT_W = 20;
    localparam int SUM_W   = 32;

    typedef enum logic [1:0] {
        S_WAIT_SOF,
        S_ACCUM,
        S_DONE
    } state_e;

    typedef struct packed {
        logic               valid;
        logic               match;
        logic               sof;
        logic               eof;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pix_s;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
        logic [COUNT_W-1:0] count;
    } acc_s;

    // An empty box has min above max so the first match overwrites both.
    localparam logic [COORD_W-1:0] EMPTY_MIN   = '1;
    localparam logic [COORD_W-1:0] EMPTY_MAX   = '0;
    localparam logic [COUNT_W-1:0] EMPTY_COUNT = '0;
    localparam acc_s ACC_EMPTY = '{x_min: EMPTY_MIN, x_max: EMPTY_MAX,
                                   y_min: EMPTY_MIN, y_max: EMPTY_MAX,
                                   count: EMPTY_COUNT};

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{(SUM_W + 1 - COORD_W){1'b0}}, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/rgb_blob_classify.sv
// Stage 1 of the blob tracker: threshold window compare, SOF/EOF decode and
// register slice. Thresholds are captured on every SOF pixel.
module rgb_blob_classify import rgb_blob_pkg::*; #(
    parameter int VIDEO_W = 1280,
    parameter int VIDEO_H = 720
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COLOR_W-1:0] rgb_r,
    input  logic [COLOR_W-1:0] rgb_g,
    input  logic [COLOR_W-1:0] rgb_b,
    input  logic [COORD_W-1:0] rgb_x,
    input  logic [COORD_W-1:0] rgb_y,
    input  logic               rgb_valid,
    input  logic [COLOR_W-1:0] th_r_min,
    input  logic [COLOR_W-1:0] th_g_max,
    input  logic [COLOR_W-1:0] th_b_max,
    output pix_s               pix
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(VIDEO_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VIDEO_H - 1);

    logic               sof;
    logic               eof;
    logic [COLOR_W-1:0] th_r_min_q;
    logic [COLOR_W-1:0] th_g_max_q;
    logic [COLOR_W-1:0] th_b_max_q;
    logic [COLOR_W-1:0] r_min;
    logic [COLOR_W-1:0] g_max;
    logic [COLOR_W-1:0] b_max;

    // The SOF pixel is judged against the thresholds being latched with it.
    always_comb begin
        sof   = rgb_valid && (rgb_x == '0) && (rgb_y == '0);
        eof   = rgb_valid && (rgb_x == X_LAST) && (rgb_y == Y_LAST);
        r_min = sof ? th_r_min : th_r_min_q;
        g_max = sof ? th_g_max : th_g_max_q;
        b_max = sof ? th_b_max : th_b_max_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix        <= '0;
            th_r_min_q <= '0;
            th_g_max_q <= '0;
            th_b_max_q <= '0;
        end else begin
            if (sof) begin
                th_r_min_q <= th_r_min;
                th_g_max_q <= th_g_max;
                th_b_max_q <= th_b_max;
            end
            pix.valid <= rgb_valid;
            pix.match <= rgb_valid && (rgb_r >= r_min) && (rgb_g <= g_max) && (rgb_b <= b_max);
            pix.sof   <= sof;
            pix.eof   <= eof;
            pix.x     <= rgb_x;
            pix.y     <= rgb_y;
        end
    end

endmodule

// File: rtl/rgb_blob_box.sv
// Per-frame colour-blob bounding box and match counter with done strobe.
// Define RGB_BLOB_CENTROID_EN to add saturating X/Y coordinate sums.
//
//   state      | meaning
//   S_WAIT_SOF | idle, pixels ignored until a start-of-frame pixel
//   S_ACCUM    | accumulating matches of the current frame
//   S_DONE     | one cycle: publish results, pulse BOX_DONE
module rgb_blob_box import rgb_blob_pkg::*; #(
    parameter int VIDEO_W    = 1280,
    parameter int VIDEO_H    = 720,
    parameter int MIN_PIXELS = 16
) (
    input  logic               RGB_CLK,
    input  logic               reset_n,
    input  logic [COLOR_W-1:0] RGB_R,
    input  logic [COLOR_W-1:0] RGB_G,
    input  logic [COLOR_W-1:0] RGB_B,
    input  logic [COORD_W-1:0] RGB_X,
    input  logic [COORD_W-1:0] RGB_Y,
    input  logic               RGB_VALID,
    input  logic [COLOR_W-1:0] TH_R_MIN,
    input  logic [COLOR_W-1:0] TH_G_MAX,
    input  logic [COLOR_W-1:0] TH_B_MAX,
    output logic [COORD_W-1:0] BOX_X_MIN,
    output logic [COORD_W-1:0] BOX_X_MAX,
    output logic [COORD_W-1:0] BOX_Y_MIN,
    output logic [COORD_W-1:0] BOX_Y_MAX,
    output logic [COUNT_W-1:0] BOX_COUNT,
    output logic               BOX_FOUND,
`ifdef RGB_BLOB_CENTROID_EN
    output logic [SUM_W-1:0]   BOX_SUM_X,
    output logic [SUM_W-1:0]   BOX_SUM_Y,
`endif
    output logic               BOX_DONE
);

    pix_s               pix;
    state_e             state;
    acc_s               acc;
    acc_s               acc_load;
    acc_s               acc_step;
    logic               acc_found;
    logic [COORD_W-1:0] prev_y;

    rgb_blob_classify #(
        .VIDEO_W (VIDEO_W),
        .VIDEO_H (VIDEO_H)
    ) u_classify (
        .clk       (RGB_CLK),
        .reset_n   (reset_n),
        .rgb_r     (RGB_R),
        .rgb_g     (RGB_G),
        .rgb_b     (RGB_B),
        .rgb_x     (RGB_X),
        .rgb_y     (RGB_Y),
        .rgb_valid (RGB_VALID),
        .th_r_min  (TH_R_MIN),
        .th_g_max  (TH_G_MAX),
        .th_b_max  (TH_B_MAX),
        .pix       (pix)
    );

`ifdef RGB_BLOB_CENTROID_EN
    logic [SUM_W-1:0] sum_x;
    logic [SUM_W-1:0] sum_y;
`endif

    always_comb begin
        acc_load = ACC_EMPTY;
        if (pix.match) begin
            acc_load.x_min = pix.x;
            acc_load.x_max = pix.x;
            acc_load.y_min = pix.y;
            acc_load.y_max = pix.y;
            acc_load.count = COUNT_W'(1);
        end
        acc_step = acc;
        if (pix.match) begin
            acc_step.x_min = (pix.x < acc.x_min) ? pix.x : acc.x_min;
            acc_step.x_max = (pix.x > acc.x_max) ? pix.x : acc.x_max;
            acc_step.y_min = (pix.y < acc.y_min) ? pix.y : acc.y_min;
            acc_step.y_max = (pix.y > acc.y_max) ? pix.y : acc.y_max;
            acc_step.count = (acc.count == '1) ? acc.count : acc.count + COUNT_W'(1);
        end
        acc_found = (acc.count >= COUNT_W'(MIN_PIXELS));
    end

    always_ff @(posedge RGB_CLK) begin
        if (!reset_n) begin
            state     <= S_WAIT_SOF;
            acc       <= ACC_EMPTY;
            prev_y    <= '0;
            BOX_X_MIN <= '0;
            BOX_X_MAX <= '0;
            BOX_Y_MIN <= '0;
            BOX_Y_MAX <= '0;
            BOX_COUNT <= '0;
            BOX_FOUND <= 1'b0;
            BOX_DONE  <= 1'b0;
`ifdef RGB_BLOB_CENTROID_EN
            sum_x     <= '0;
            sum_y     <= '0;
            BOX_SUM_X <= '0;
            BOX_SUM_Y <= '0;
`endif
        end else begin
            BOX_DONE <= 1'b0;
            if (pix.valid) begin
                prev_y <= pix.y;
            end
            // A SOF pixel is always at (0,0), so reloading the sums means clearing them.
            if (pix.valid && pix.sof) begin
                acc <= acc_load;
`ifdef RGB_BLOB_CENTROID_EN
                sum_x <= '0;
                sum_y <= '0;
`endif
            end
            case (state)
                S_WAIT_SOF: begin
                    if (pix.valid && pix.sof) begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (pix.valid && !pix.sof) begin
                        if (pix.y < prev_y) begin
                            state <= S_WAIT_SOF;
                        end else begin
                            acc <= acc_step;
`ifdef RGB_BLOB_CENTROID_EN
                            if (pix.match) begin
                                sum_x <= sat_add(sum_x, pix.x);
                                sum_y <= sat_add(sum_y, pix.y);
                            end
`endif
                            if (pix.eof) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    BOX_DONE  <= 1'b1;
                    BOX_COUNT <= acc.count;
                    BOX_FOUND <= acc_found;
                    BOX_X_MIN <= acc_found ? acc.x_min : '0;
                    BOX_X_MAX <= acc_found ? acc.x_max : '0;
                    BOX_Y_MIN <= acc_found ? acc.y_min : '0;
                    BOX_Y_MAX <= acc_found ? acc.y_max : '0;
`ifdef RGB_BLOB_CENTROID_EN
                    BOX_SUM_X <= acc_found ? sum_x : '0;
                    BOX_SUM_Y <= acc_found ? sum_y : '0;
`endif
                    state <= (pix.valid && pix.sof) ? S_ACCUM : S_WAIT_SOF;
                end
                default: state <= S_WAIT_SOF;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_blob_box.sv
// Scoreboard bench for rgb_blob_box on an 8x4 frame with MIN_PIXELS=2.
// Build with RGB_BLOB_CENTROID_EN to also check the coordinate sums.
module tb_rgb_blob_box;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] RGB_R, RGB_G, RGB_B, RGB_X, RGB_Y;
    logic        RGB_VALID;
    logic [11:0] TH_R_MIN, TH_G_MAX, TH_B_MAX;
    logic [11:0] BOX_X_MIN, BOX_X_MAX, BOX_Y_MIN, BOX_Y_MAX;
    logic [19:0] BOX_COUNT;
    logic        BOX_FOUND, BOX_DONE;
`ifdef RGB_BLOB_CENTROID_EN
    logic [31:0] BOX_SUM_X, BOX_SUM_Y;
`endif

    rgb_blob_box #(.VIDEO_W(8), .VIDEO_H(4), .MIN_PIXELS(2)) dut (
        .RGB_CLK   (clk),
        .reset_n   (reset_n),
        .RGB_R     (RGB_R),
        .RGB_G     (RGB_G),
        .RGB_B     (RGB_B),
        .RGB_X     (RGB_X),
        .RGB_Y     (RGB_Y),
        .RGB_VALID (RGB_VALID),
        .TH_R_MIN  (TH_R_MIN),
        .TH_G_MAX  (TH_G_MAX),
        .TH_B_MAX  (TH_B_MAX),
        .BOX_X_MIN (BOX_X_MIN),
        .BOX_X_MAX (BOX_X_MAX),
        .BOX_Y_MIN (BOX_Y_MIN),
        .BOX_Y_MAX (BOX_Y_MAX),
        .BOX_COUNT (BOX_COUNT),
        .BOX_FOUND (BOX_FOUND),
`ifdef RGB_BLOB_CENTROID_EN
        .BOX_SUM_X (BOX_SUM_X),
        .BOX_SUM_Y (BOX_SUM_Y),
`endif
        .BOX_DONE  (BOX_DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] x_min, x_max, y_min, y_max;
        logic [19:0] count;
        logic        found;
        logic [31:0] sum_x, sum_y;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    // Hand-computed frames: bit y*8+x set means pixel (x,y) is red.
    localparam logic [31:0] MASK_A   = 32'h0008_2400; // (2,1) (5,1) (3,2)
    localparam logic [31:0] MASK_B   = 32'h8000_0000; // (7,3)
    localparam logic [31:0] MASK_C   = 32'h8010_0001; // (0,0) (4,2) (7,3)
    localparam logic [31:0] MASK_RST = 32'h0000_0040; // (6,0)

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] xmin, input logic [11:0] xmax,
                                input logic [11:0] ymin, input logic [11:0] ymax,
                                input logic [19:0] cnt, input logic fnd,
                                input logic [31:0] sx, input logic [31:0] sy);
        exp_t e;
        e.cyc = 0;
        e.x_min = xmin; e.x_max = xmax; e.y_min = ymin; e.y_max = ymax;
        e.count = cnt; e.found = fnd; e.sum_x = sx; e.sum_y = sy;
        return e;
    endfunction

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, "_x_min"}, 32'(BOX_X_MIN), 32'(e.x_min));
        chk({tag, "_x_max"}, 32'(BOX_X_MAX), 32'(e.x_max));
        chk({tag, "_y_min"}, 32'(BOX_Y_MIN), 32'(e.y_min));
        chk({tag, "_y_max"}, 32'(BOX_Y_MAX), 32'(e.y_max));
        chk({tag, "_count"}, 32'(BOX_COUNT), 32'(e.count));
        chk({tag, "_found"}, 32'(BOX_FOUND), 32'(e.found));
`ifdef RGB_BLOB_CENTROID_EN
        chk({tag, "_sum_x"}, BOX_SUM_X, e.sum_x);
        chk({tag, "_sum_y"}, BOX_SUM_Y, e.sum_y);
`endif
    endtask

    // Monitor: every BOX_DONE pops one expected frame result.
    always @(negedge clk) begin
        if (BOX_DONE) begin
            if (prev_done) begin
                checks++; errors++;
                $display("FAIL done_width: BOX_DONE high for a second cycle at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: BOX_DONE at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk_outputs("done", mon_e);
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            mon_e = sb.pop_front();
            checks++; errors++;
            $display("FAIL missing_done: no BOX_DONE at cycle %0d, expected at %0d", cyc, mon_e.cyc);
        end
        prev_done = BOX_DONE;
    end

    task automatic drive(input int x, input int y, input bit m, input bit v);
        @(negedge clk);
        RGB_VALID = v;
        RGB_X = 12'(x);
        RGB_Y = 12'(y);
        RGB_R = m ? 12'hFFF : 12'h000;
        RGB_G = 12'h000;
        RGB_B = 12'h000;
    endtask

    // Invalid cycles carry a matching colour at (0,0) so they must be ignored.
    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'b1, 1'b0);
    endtask

    task automatic send_rows(input int y0, input int y1, input logic [31:0] mask,
                             input bit gaps, input bit done_exp, input exp_t e,
                             input bit corrupt_th);
        exp_t ee;
        ee = e;
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < 8; x++) begin
                drive(x, y, mask[y*8+x], 1'b1);
                if (corrupt_th && x == 1 && y == 0) TH_R_MIN = 12'h000;
                if (done_exp && x == 7 && y == 3) begin
                    ee.cyc = cyc + 3;
                    sb.push_back(ee);
                end
                if (gaps) idle(1);
            end
        end
        if (corrupt_th) TH_R_MIN = 12'h800;
    endtask

    exp_t exp_a, exp_b, exp_c, exp_zero;

    initial begin
        exp_a    = mk(12'd2, 12'd5, 12'd1, 12'd2, 20'd3, 1'b1, 32'd10, 32'd4);
        exp_b    = mk(12'd0, 12'd0, 12'd0, 12'd0, 20'd1, 1'b0, 32'd0, 32'd0);
        exp_c    = mk(12'd0, 12'd7, 12'd0, 12'd3, 20'd3, 1'b1, 32'd11, 32'd5);
        exp_zero = mk(12'd0, 12'd0, 12'd0, 12'd0, 20'd0, 1'b0, 32'd0, 32'd0);

        reset_n = 1'b0;
        RGB_VALID = 1'b0;
        RGB_R = '0; RGB_G = '0; RGB_B = '0; RGB_X = '0; RGB_Y = '0;
        TH_R_MIN = 12'h800; TH_G_MAX = 12'h100; TH_B_MAX = 12'h100;
        repeat (3) @(negedge clk);
        chk_outputs("reset", exp_zero);
        chk("reset_done", 32'(BOX_DONE), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Three back-to-back frames: each SOF lands on the previous S_DONE cycle.
        send_rows(0, 3, MASK_A, 1'b0, 1'b1, exp_a, 1'b0);
        send_rows(0, 3, MASK_B, 1'b0, 1'b1, exp_b, 1'b0);
        send_rows(0, 3, MASK_A, 1'b1, 1'b1, exp_a, 1'b1);
        idle(4);

        // Abort: Y falls back from 2 to 0 at X=4.
        send_rows(0, 2, MASK_A, 1'b0, 1'b0, exp_zero, 1'b0);
        drive(4, 0, 1'b1, 1'b1);
        idle(6);
        chk_outputs("abort_hold", exp_a);
        send_rows(0, 3, MASK_C, 1'b0, 1'b1, exp_c, 1'b0);
        idle(4);

        // Frame restart: a stray match before an unexpected SOF is dropped.
        send_rows(0, 0, MASK_RST, 1'b0, 1'b0, exp_zero, 1'b0);
        send_rows(0, 3, MASK_A, 1'b0, 1'b1, exp_a, 1'b0);
        idle(5);

        // One-cycle reset mid-frame; the frame tail must not produce a result.
        send_rows(0, 1, MASK_A, 1'b0, 1'b0, exp_zero, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        RGB_VALID = 1'b0;
        @(negedge clk);
        chk_outputs("midreset", exp_zero);
        chk("midreset_done", 32'(BOX_DONE), 32'd0);
        reset_n = 1'b1;
        send_rows(2, 3, MASK_A, 1'b0, 1'b0, exp_zero, 1'b0);
        idle(5);
        chk_outputs("after_tail", exp_zero);
        send_rows(0, 3, MASK_A, 1'b0, 1'b1, exp_a, 1'b0);
        idle(8);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
